// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer and the units it gates:
// width helpers and the named mode indices the functional units decode.
package mode_pkg;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width needed to hold indices 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int DEFAULT_NUM_MODES = 5;
  localparam int MODE_W            = width_of(DEFAULT_NUM_MODES);

  // Mode indices as decoded by the consuming datapath/display units.
  localparam int MODE_ADD  = 0;
  localparam int MODE_SUB  = 1;
  localparam int MODE_MUL  = 2;
  localparam int MODE_DIV  = 3;
  localparam int MODE_SHOW = 4;

endpackage

// File: rtl/mode_sequencer_if.sv
// Board-side bundle of the mode sequencer: raw keys, control strobes and
// the mode/enable outputs consumed by the functional units.
//
// Handshake: there is no ready. load is a single-cycle strobe that the
// sequencer always accepts on the edge where it is sampled high; the outcome
// appears on the following cycle as a mode_changed pulse (valid target) or a
// load_err pulse (out-of-range target). hold is a level, not a handshake.
interface mode_sequencer_if #(
  parameter int NUM_MODES = 5
);
  import mode_pkg::*;

  localparam int MODE_W = width_of(NUM_MODES);

  logic              key_next_n;
  logic              key_prev_n;
  logic              hold;
  logic              load;
  logic [MODE_W-1:0] load_mode;
  logic [MODE_W-1:0] mode;
  logic [NUM_MODES-1:0] enables;
  logic              mode_changed;
  logic              load_err;

  modport master (
    output key_next_n, key_prev_n, hold, load, load_mode,
    input  mode, enables, mode_changed, load_err
  );

  modport slave (
    input  key_next_n, key_prev_n, hold, load, load_mode,
    output mode, enables, mode_changed, load_err
  );

endinterface

// File: rtl/mode_sequencer_debounce.sv
// One pushbutton path: two-flop synchroniser, stability counter and a
// single-cycle press pulse on the released->pressed transition.
module key_debounce
  import mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = width_of(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;   // debounced level, 1 = released
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fill;    // marks when sync2 carries a real post-reset sample
  logic             armed;   // a released level has been seen since reset
  logic             flip;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  assign flip  = (sync2 != level) && (cnt == CNT_LAST);
  // Press fires on the same cycle the level is about to go pressed, so the
  // consumer's register update lands on the flip edge. A key held through
  // reset leaves armed low, so its first debounced press is swallowed.
  assign press = flip && !sync2 && armed;

  // Synchronise, count the disagreement run, and track arming after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      if (sync2 != level) begin
        if (flip) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      if (fill[1] && sync2 && level) armed <= 1'b1;
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Board mode register: steps forward/back from two debounced keys or loads
// directly, and drives a registered one-hot enable bus for the mode-gated
// functional units.
module mode_sequencer
  import mode_pkg::*;
#(
  parameter int NUM_MODES       = 5,
  parameter int RESET_MODE      = 0,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input logic              clk,
  input logic              rst_n,
  mode_sequencer_if.slave  bus
);

  localparam int MODE_W = width_of(NUM_MODES);
  localparam logic [MODE_W-1:0] LAST_MODE  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] START_MODE = MODE_W'(RESET_MODE);
  localparam logic [MODE_W:0]   MODE_LIMIT = (MODE_W + 1)'(NUM_MODES);

  logic                 press_next;
  logic                 press_prev;
  logic [MODE_W-1:0]    mode_q;
  logic [NUM_MODES-1:0] enables_q;
  logic                 changed_q;
  logic                 load_err_q;
  logic [MODE_W-1:0]    next_mode;
  logic [MODE_W-1:0]    prev_mode;
  logic                 load_ok;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_next_n),
    .press (press_next)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_prev_n),
    .press (press_prev)
  );

  function automatic logic [NUM_MODES-1:0] onehot(input logic [MODE_W-1:0] m);
    return NUM_MODES'(1) << m;
  endfunction

  // Wrapping neighbours and load range check; load is the only way an
  // arbitrary code can reach the register, so it alone is checked.
  always_comb begin
    next_mode = (mode_q == LAST_MODE) ? '0 : mode_q + 1'b1;
    prev_mode = (mode_q == '0) ? LAST_MODE : mode_q - 1'b1;
    load_ok   = ({1'b0, bus.load_mode} < MODE_LIMIT);
  end

  // Mode update in priority order: load, hold, cancel, next, prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= START_MODE;
      enables_q  <= onehot(START_MODE);
      changed_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      changed_q  <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        if (load_ok) begin
          mode_q    <= bus.load_mode;
          enables_q <= onehot(bus.load_mode);
          changed_q <= 1'b1;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (!bus.hold) begin
        if (press_next && !press_prev) begin
          mode_q    <= next_mode;
          enables_q <= onehot(next_mode);
          changed_q <= 1'b1;
        end else if (press_prev && !press_next) begin
          mode_q    <= prev_mode;
          enables_q <= onehot(prev_mode);
          changed_q <= 1'b1;
        end
      end
    end
  end

  assign bus.mode         = mode_q;
  assign bus.enables      = enables_q;
  assign bus.mode_changed = changed_q;
  assign bus.load_err     = load_err_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with NUM_MODES=5, DEBOUNCE_CYCLES=4.
module tb_mode_sequencer;
  import mode_pkg::*;

  localparam int NM = 5;
  localparam int DC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mode_sequencer_if #(.NUM_MODES(NM)) bus();

  mode_sequencer #(
    .NUM_MODES       (NM),
    .RESET_MODE      (0),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  int n_cmp    = 0;
  int n_err    = 0;
  int mc_count = 0;
  int mc_base  = 0;
  logic [31:0] exp_q[$];

  // Count mode_changed pulses, sampled mid-cycle.
  always @(negedge clk) if (bus.mode_changed === 1'b1) mc_count++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the selected keys low for low_cycles, release, let release debounce.
  task automatic tap(input bit nxt, input bit prv, input int low_cycles);
    if (nxt) bus.key_next_n = 1'b0;
    if (prv) bus.key_prev_n = 1'b0;
    tick(low_cycles);
    bus.key_next_n = 1'b1;
    bus.key_prev_n = 1'b1;
    tick(12);
  endtask

  task automatic load_pulse(input logic [2:0] m);
    bus.load_mode = m;
    bus.load      = 1'b1;
    tick(1);
    bus.load      = 1'b0;
  endtask

  initial begin
    bus.key_next_n = 1'b1;
    bus.key_prev_n = 1'b1;
    bus.hold       = 1'b0;
    bus.load       = 1'b0;
    bus.load_mode  = '0;

    // Reset values.
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_eq("rst_mode", bus.mode, 0);
    check_eq("rst_enables", bus.enables, 5'b00001);
    check_eq("rst_changed", bus.mode_changed, 0);
    check_eq("rst_load_err", bus.load_err, 0);
    tick(5);

    // First press: mode moves on the 6th edge after the key falls.
    bus.key_next_n = 1'b0;
    tick(5);
    check_eq("lat_before", bus.mode, 0);
    tick(1);
    check_eq("lat_mode", bus.mode, 1);
    check_eq("lat_enables", bus.enables, 5'b00010);
    check_eq("lat_changed", bus.mode_changed, 1);
    tick(1);
    check_eq("lat_changed_drop", bus.mode_changed, 0);
    tick(2);
    bus.key_next_n = 1'b1;
    tick(12);

    // Five next presses from mode 0 wrap through 1,2,3,4,0.
    load_pulse(3'd0);
    check_eq("load0_mode", bus.mode, 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'((i + 1) % NM));
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      tap(1'b1, 1'b0, 8);
      check_eq("wrap_mode", bus.mode, e);
      check_eq("wrap_enables", bus.enables, 32'(1) << e);
    end

    // Prev from 0 wraps to the top mode.
    tap(1'b0, 1'b1, 8);
    check_eq("prev_wrap_mode", bus.mode, 4);
    check_eq("prev_wrap_enables", bus.enables, 5'b10000);

    // Three-cycle glitch is one short of the debounce length: filtered.
    mc_base = mc_count;
    bus.key_next_n = 1'b0;
    tick(3);
    bus.key_next_n = 1'b1;
    tick(12);
    check_eq("glitch_mode", bus.mode, 4);
    check_eq("glitch_pulses", mc_count - mc_base, 0);

    // Key held for 100 cycles steps exactly once.
    mc_base = mc_count;
    tap(1'b1, 1'b0, 100);
    check_eq("held_mode", bus.mode, 0);
    check_eq("held_pulses", mc_count - mc_base, 1);

    // Both keys together cancel.
    mc_base = mc_count;
    tap(1'b1, 1'b1, 8);
    check_eq("both_mode", bus.mode, 0);
    check_eq("both_pulses", mc_count - mc_base, 0);

    // Press under hold is discarded, and nothing fires after hold drops.
    mc_base = mc_count;
    bus.hold = 1'b1;
    tap(1'b1, 1'b0, 8);
    bus.hold = 1'b0;
    tick(12);
    check_eq("hold_mode", bus.mode, 0);
    check_eq("hold_pulses", mc_count - mc_base, 0);

    // Load coincident with a press wins; single change pulse.
    mc_base = mc_count;
    bus.key_next_n = 1'b0;
    tick(5);
    bus.load_mode = 3'd3;
    bus.load      = 1'b1;
    tick(1);
    bus.load      = 1'b0;
    check_eq("loadpress_mode", bus.mode, 3);
    check_eq("loadpress_changed", bus.mode_changed, 1);
    tick(3);
    bus.key_next_n = 1'b1;
    tick(12);
    check_eq("loadpress_mode_after", bus.mode, 3);
    check_eq("loadpress_pulses", mc_count - mc_base, 1);

    // Out-of-range load: error pulse, mode untouched.
    load_pulse(3'd6);
    check_eq("badload_err", bus.load_err, 1);
    check_eq("badload_mode", bus.mode, 3);
    check_eq("badload_changed", bus.mode_changed, 0);
    tick(1);
    check_eq("badload_err_drop", bus.load_err, 0);

    // Reloading the current mode still reports a change.
    load_pulse(3'd3);
    check_eq("sameload_changed", bus.mode_changed, 1);
    check_eq("sameload_mode", bus.mode, 3);

    // Reset mid-debounce at mode 2, key held through release.
    load_pulse(3'd2);
    tick(2);
    check_eq("pre_rst_mode", bus.mode, 2);
    bus.key_next_n = 1'b0;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_mode", bus.mode, 0);
    check_eq("midrst_enables", bus.enables, 5'b00001);
    check_eq("midrst_changed", bus.mode_changed, 0);
    tick(2);
    rst_n = 1'b1;
    mc_base = mc_count;
    tick(20);
    check_eq("held_rst_mode", bus.mode, 0);
    check_eq("held_rst_pulses", mc_count - mc_base, 0);
    bus.key_next_n = 1'b1;
    tick(12);
    tap(1'b1, 1'b0, 8);
    check_eq("rearm_mode", bus.mode, 1);
    check_eq("rearm_enables", bus.enables, 5'b00010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
